tt_sweep: RTL and testbench

//  Sequential stimulus/response harness placed around a combinational 4-input logic stage (a,b,c,d -> s).

---
 rtl/tt_sweep_pkg.sv | 13 +
 rtl/tt_popcount.sv | 18 +
 rtl/tt_sweep.sv | 110 +++++++++++
 tb/tb_tt_sweep.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_sweep_pkg.sv
// Shared types and defaults for the truth-table sweep harness.
package tt_sweep_pkg;

  localparam int unsigned N_IN_DEF   = 4;
  localparam int unsigned SETTLE_DEF = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    RESULT = 2'd2
  } state_t;

endpackage

// File: rtl/tt_popcount.sv
// Combinational population count of a truth-table difference word.
module tt_popcount #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 5
) (
  input  logic [IN_W-1:0]  bits,
  output logic [OUT_W-1:0] count
);

  // Sum of set bits.
  always_comb begin
    count = '0;
    for (int i = 0; i < int'(IN_W); i++) begin
      count = count + OUT_W'(bits[i]);
    end
  end

endmodule

// File: rtl/tt_sweep.sv
// Sweeps every input vector through a combinational stage, builds its truth
// table and compares it with an expected table; result on a valid/ready port.
module tt_sweep
  import tt_sweep_pkg::*;
#(
  parameter int unsigned N_IN   = N_IN_DEF,
  parameter int unsigned SETTLE = SETTLE_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [(2**N_IN)-1:0] exp_tt,
  output logic [N_IN-1:0]      vec_out,
  input  logic                 s_in,
  output logic                 busy,
  output logic                 tt_valid,
  input  logic                 tt_ready,
  output logic [(2**N_IN)-1:0] tt_data,
  output logic                 mismatch,
  output logic [N_IN:0]        err_cnt
);

  localparam int unsigned TT_W  = 2**N_IN;
  localparam int unsigned ERR_W = N_IN + 1;
  localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [N_IN-1:0]  vec;
  logic [TT_W-1:0]  exp_q;
  logic [TT_W-1:0]  tt_next;
  logic [TT_W-1:0]  diff;
  logic [ERR_W-1:0] pop;
  logic             last_step;
  logic             last_vec;

  assign last_step = (cnt == CNT_W'(SETTLE - 1));
  assign last_vec  = (vec == N_IN'(TT_W - 1));
  assign vec_out   = vec;

  // Table as it will be after the current sample lands; lets the final
  // compare and popcount be registered on the same edge as the last sample.
  always_comb begin
    tt_next      = tt_data;
    tt_next[vec] = s_in;
  end

  assign diff = tt_next ^ exp_q;

  tt_popcount #(
    .IN_W  (TT_W),
    .OUT_W (ERR_W)
  ) u_popcount (
    .bits  (diff),
    .count (pop)
  );

  // Sweep controller: accept start, step vectors with settle delay, hold result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      vec      <= '0;
      exp_q    <= '0;
      busy     <= 1'b0;
      tt_valid <= 1'b0;
      tt_data  <= '0;
      mismatch <= 1'b0;
      err_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= APPLY;
            vec   <= '0;
            cnt   <= '0;
            exp_q <= exp_tt;
            busy  <= 1'b1;
          end
        end
        APPLY: begin
          if (last_step) begin
            cnt     <= '0;
            tt_data <= tt_next;
            if (last_vec) begin
              state    <= RESULT;
              vec      <= '0;
              tt_valid <= 1'b1;
              mismatch <= |diff;
              err_cnt  <= pop;
            end else begin
              vec <= vec + N_IN'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESULT: begin
          if (tt_ready) begin
            state    <= IDLE;
            tt_valid <= 1'b0;
            busy     <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_sweep.sv
// Bench for tt_sweep: SETTLE=2 and SETTLE=1 instances around a modelled stage.
module tb_tt_sweep;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic        ready_a = 1'b0, ready_b = 1'b0;
  logic [15:0] exp_tt = 16'h0;
  logic [3:0]  vec_a, vec_b;
  logic        s_in_a, s_in_b;
  logic        busy_a, busy_b, valid_a, valid_b, mis_a, mis_b;
  logic [15:0] data_a, data_b;
  logic [4:0]  err_a, err_b;

  int          mode = 0;
  logic [15:0] stage_tbl = 16'h0;
  bit          sel = 1'b0;
  int          checks = 0;
  int          errors = 0;

  logic [3:0]  vec_v;
  logic        busy_v, valid_v, mis_v;
  logic [15:0] data_v;
  logic [4:0]  err_v;

  always #5 clk = ~clk;

  tt_sweep #(.N_IN(4), .SETTLE(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .exp_tt(exp_tt),
    .vec_out(vec_a), .s_in(s_in_a), .busy(busy_a), .tt_valid(valid_a),
    .tt_ready(ready_a), .tt_data(data_a), .mismatch(mis_a), .err_cnt(err_a)
  );

  tt_sweep #(.N_IN(4), .SETTLE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .exp_tt(exp_tt),
    .vec_out(vec_b), .s_in(s_in_b), .busy(busy_b), .tt_valid(valid_b),
    .tt_ready(ready_b), .tt_data(data_b), .mismatch(mis_b), .err_cnt(err_b)
  );

  // Stage under test: a few fixed logic functions or an arbitrary lookup table.
  function automatic logic stage_fn(input int m, input logic [15:0] t, input logic [3:0] v);
    case (m)
      0:       return v[3] & v[2];
      1:       return v[0];
      2:       return ~v[1];
      default: return t[v];
    endcase
  endfunction

  // Reference truth table: evaluate the stage on every input combination.
  function automatic logic [15:0] model_tt(input int m, input logic [15:0] t);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = stage_fn(m, t, 4'(i));
    return r;
  endfunction

  always_comb s_in_a = stage_fn(mode, stage_tbl, vec_a);
  always_comb s_in_b = stage_fn(mode, stage_tbl, vec_b);

  always_comb begin
    vec_v   = sel ? vec_b   : vec_a;
    busy_v  = sel ? busy_b  : busy_a;
    valid_v = sel ? valid_b : valid_a;
    mis_v   = sel ? mis_b   : mis_a;
    data_v  = sel ? data_b  : data_a;
    err_v   = sel ? err_b   : err_a;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel) start_b = v; else start_a = v;
  endtask

  task automatic set_ready(input logic v);
    if (sel) ready_b = v; else ready_a = v;
  endtask

  // One sweep from start pulse to tt_valid; checks stepping, latency and result.
  task automatic sweep(input string tag, input logic [15:0] exp, input logic [15:0] w_data,
                       input logic w_mis, input logic [4:0] w_err);
    int settle;
    int k;
    int bad;
    settle = sel ? 1 : 2;
    @(posedge clk); #1;
    set_start(1'b1);
    exp_tt = exp;
    @(posedge clk); #1;
    set_start(1'b0);
    exp_tt = ~exp;
    check({tag, "_busy"}, 32'(busy_v), 32'd1);
    k = 0;
    bad = 0;
    while (valid_v !== 1'b1 && k < 200) begin
      if (vec_v !== 4'(k / settle)) bad++;
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_steps"}, 32'(bad), 32'd0);
    check({tag, "_latency"}, 32'(k), 32'(16 * settle));
    check({tag, "_data"}, 32'(data_v), 32'(w_data));
    check({tag, "_mismatch"}, 32'(mis_v), 32'(w_mis));
    check({tag, "_errcnt"}, 32'(err_v), 32'(w_err));
    check({tag, "_vec_in_result"}, 32'(vec_v), 32'd0);
  endtask

  // Complete the handshake with start asserted, which must be ignored.
  task automatic handshake(input string tag, input logic [15:0] w_data);
    set_ready(1'b1);
    set_start(1'b1);
    @(posedge clk); #1;
    set_ready(1'b0);
    set_start(1'b0);
    check({tag, "_hs_valid"}, 32'(valid_v), 32'd0);
    check({tag, "_hs_busy"}, 32'(busy_v), 32'd0);
    check({tag, "_hs_data_kept"}, 32'(data_v), 32'(w_data));
    @(posedge clk); #1;
    check({tag, "_idle_busy"}, 32'(busy_v), 32'd0);
  endtask

  typedef struct {
    int          m;
    logic [15:0] tbl;
    logic [15:0] exp;
    logic [15:0] data;
    logic        mis;
    logic [4:0]  err;
    bit          s;
  } vec_t;

  vec_t tv [8];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int k;
    int hits;
    int pulse_at [3];
    logic [15:0] held;

    tv[0] = '{0, 16'h0, 16'hF000, 16'hF000, 1'b0, 5'd0,  1'b0};
    tv[1] = '{1, 16'h0, 16'h0000, 16'hAAAA, 1'b1, 5'd8,  1'b0};
    tv[2] = '{2, 16'h0, 16'h3333, 16'h3333, 1'b0, 5'd0,  1'b1};
    tv[3] = '{0, 16'h0, 16'h0F0F, 16'hF000, 1'b1, 5'd12, 1'b1};
    for (int i = 4; i < 8; i++) begin
      tv[i].m   = 3;
      tv[i].tbl = 16'($urandom);
      tv[i].s   = (i % 3) == 0;
      tv[i].exp = (i % 2) ? model_tt(3, tv[i].tbl) : 16'($urandom);
      tv[i].data = model_tt(3, tv[i].tbl);
      tv[i].mis  = (tv[i].data != tv[i].exp);
      tv[i].err  = 5'($countones(tv[i].data ^ tv[i].exp));
    end

    #2;
    check("reset_a", {busy_a, valid_a, mis_a, err_a, vec_a, data_a}, 32'd0);
    check("reset_b", {busy_b, valid_b, mis_b, err_b, vec_b, data_b}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven sweeps on both instances.
    for (int i = 0; i < 8; i++) begin
      sel = tv[i].s;
      mode = tv[i].m;
      stage_tbl = tv[i].tbl;
      sweep($sformatf("vec%0d", i), tv[i].exp, tv[i].data, tv[i].mis, tv[i].err);
      handshake($sformatf("vec%0d", i), tv[i].data);
    end

    // Backpressure: result held while tt_ready is low, start pulses ignored.
    sel = 1'b0;
    mode = 1;
    sweep("bp", 16'h0000, 16'hAAAA, 1'b1, 5'd8);
    held = data_v;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      set_start(i[0]);
      @(posedge clk); #1;
      if (valid_v !== 1'b1 || data_v !== held || busy_v !== 1'b1 ||
          mis_v !== 1'b1 || err_v !== 5'd8 || vec_v !== 4'd0) bad++;
    end
    set_start(1'b0);
    check("bp_held", 32'(bad), 32'd0);
    handshake("bp", 16'hAAAA);

    // Asynchronous reset in the middle of a sweep.
    mode = 0;
    @(posedge clk); #1;
    set_start(1'b1);
    @(posedge clk); #1;
    set_start(1'b0);
    k = 0;
    while (vec_a !== 4'd5 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("rst_reach_vec5", 32'(vec_a), 32'd5);
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", {busy_a, valid_a, mis_a, err_a, vec_a, data_a}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sweep("after_rst", 16'hF000, 16'hF000, 1'b0, 5'd0);
    handshake("after_rst", 16'hF000);

    // Back-to-back sweeps with start and tt_ready held high.
    mode = 1;
    exp_tt = 16'hAAAA;
    @(posedge clk); #1;
    start_a = 1'b1;
    ready_a = 1'b1;
    hits = 0;
    bad = 0;
    for (int e = 1; e < 150 && hits < 3; e++) begin
      @(posedge clk); #1;
      if (valid_a === 1'b1) begin
        pulse_at[hits] = e;
        hits++;
        if (data_a !== 16'hAAAA || mis_a !== 1'b0 || err_a !== 5'd0) bad++;
      end
    end
    check("b2b_pulses", 32'(hits), 32'd3);
    check("b2b_results", 32'(bad), 32'd0);
    check("b2b_first", 32'(pulse_at[0]), 32'd33);
    check("b2b_period1", 32'(pulse_at[1] - pulse_at[0]), 32'd34);
    check("b2b_period2", 32'(pulse_at[2] - pulse_at[1]), 32'd34);
    start_a = 1'b0;
    ready_a = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
